key_counter: RTL
================

# key_counter

Push-button input block for the 12 MHz board. It samples three raw active-low push buttons, synchronises and debounces each one, and turns each press into a single-cycle event. The events drive a 3-bit up/down counter with clear. The counter value feeds the existing active-low LED display logic, and the debounced key levels are available to any other consumer.

## Interface

Parameters:
- DB_CYCLES, 120000, consecutive stable samples required to accept a level change (10 ms at 12 MHz); must be ≥ 2.
- DB_W, 17, width of each debounce counter; must satisfy 2^DB_W > DB_CYCLES.

Ports:
- CLK12M  input  1  12 MHz system clock; all state on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- BTN0  input  1  raw increment button, active-low, asynchronous to CLK12M.
- BTN1  input  1  raw decrement button, active-low, asynchronous.
- BTN2  input  1  raw clear button, active-low, asynchronous.
- CNT  output  3  counter value.
- CNT_STB  output  1  one-cycle pulse in the cycle CNT takes a value written by an accepted press.
- KEY_DOWN  output  3  debounced key levels, active-high; bit i corresponds to BTNi.

## Operation

- Per key, in order:
  - Invert the raw pin to get an active-high signal.
  - Pass it through a two-flop synchroniser (s1, s2).
  - Debounce it with stable flag `stb` and counter `dc`.
- Debounce rule, evaluated each edge:
  - If s2 == stb: dc <= 0.
  - Else if dc == DB_CYCLES-1: stb <= s2, dc <= 0.
  - Else: dc <= dc+1.
- A glitch shorter than DB_CYCLES samples never changes stb.
- press[i] is registered high for exactly one cycle on the edge where stb goes 0→1. A release (1→0) produces no event.
- Counter update, on the edge after press:
  - press[2] set: CNT <= 0. Clear wins over everything.
  - Else press[0] and press[1] both set: no change, CNT_STB stays low.
  - Else press[0]: CNT <= CNT+1, wrapping 7→0.
  - Else press[1]: CNT <= CNT-1, wrapping 0→7.
- CNT_STB is registered alongside CNT. It is high for every accepted inc, dec or clear, including a clear when CNT is already 0.
- KEY_DOWN[i] = stb[i].
- Holding a key produces exactly one event; there is no auto-repeat.

## Timing

- Reset values: CNT=0, CNT_STB=0, KEY_DOWN=000, all s1/s2/stb=0 (released), all dc=0, all press=0.
- Key press latency, counting from a raw falling edge that meets setup before rising edge 1:
  - s2 = 1 after edge 2.
  - stb and KEY_DOWN rise at edge 2+DB_CYCLES.
  - press pulse is high in the cycle after that edge.
  - CNT and CNT_STB update at edge 3+DB_CYCLES.
- Release latency: KEY_DOWN falls at edge 2+DB_CYCLES after the raw rising edge.
- Keys are independent. Presses on different keys that land on the same edge follow the priority rules above.
- Reset mid-operation clears every state immediately, including an in-flight debounce.
  - A key held across reset deassertion counts as a new press.
  - It is accepted at edge 2+DB_CYCLES after reset release, and CNT updates one edge later.
- Minimum spacing between two accepted presses of one key: 2·DB_CYCLES cycles (release debounce plus press debounce).

## Structure

- Shared constants header: `CLK_HZ` = 12000000, `DB_CYCLES_DEFAULT` = 120000, key indices `KEY_INC` = 0, `KEY_DEC` = 1, `KEY_CLR` = 2.
- Sub-module `key_debounce`:
  - Ports: clock, reset, raw active-low input, stb output, press pulse output.
  - Contains the synchroniser, dc and stb.
  - Instantiated three times.
- Top `key_counter` holds the priority logic, CNT and CNT_STB.

## Test plan

All scenarios run with DB_CYCLES=4.

- Reset: assert RST mid-simulation with BTN0 held low → CNT=0, KEY_DOWN=000, CNT_STB=0 asynchronously. After release, CNT=1 at edge 7 after reset deassertion.
- Clean press of BTN0 before edge 1 → KEY_DOWN=001 at edge 6; CNT 0→1 and a one-cycle CNT_STB at edge 7. Held for 100 cycles → no further change.
- Bounce: BTN1 low for 3 cycles, high for 1, then low and held → a single event, CNT 0→7 (wrap), exactly one CNT_STB. A 3-cycle-only pulse → no event.
- Wrap: eight BTN0 presses starting from CNT=0 → CNT sequence 1…7,0, eight CNT_STB pulses.
- Simultaneous: BTN0 and BTN1 pressed on the same edge → CNT unchanged, no CNT_STB. BTN0, BTN1 and BTN2 on the same edge with CNT=5 → CNT=0, CNT_STB=1.
- Release: BTN2 held, then released → KEY_DOWN[2] falls 6 edges after the release, no CNT_STB on release.

Source files
------------

// File: rtl/key_counter_pkg.sv
// key_counter_pkg: shared board constants and key indices for the push-button counter.
package key_counter_pkg;
  localparam int CLK_HZ            = 12000000;
  localparam int DB_CYCLES_DEFAULT = 120000;
  localparam int KEY_INC           = 0;
  localparam int KEY_DEC           = 1;
  localparam int KEY_CLR           = 2;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises one active-low raw button, debounces it and flags each press.
module key_debounce
  import key_counter_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int DB_W      = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic stb_o,
  output logic press_o
);
  logic s1_q, s2_q, stb_q, stb_d, press_q, press_d, done;
  logic [DB_W-1:0] dc_q, dc_d;
  always_comb begin
    done    = (s2_q != stb_q) && (dc_q == DB_W'(DB_CYCLES - 1));
    dc_d    = (s2_q == stb_q || done) ? '0 : dc_q + DB_W'(1);
    stb_d   = done ? s2_q : stb_q;
    press_d = done & s2_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      stb_q   <= 1'b0;
      dc_q    <= '0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= ~btn_n_i;
      s2_q    <= s1_q;
      stb_q   <= stb_d;
      dc_q    <= dc_d;
      press_q <= press_d;
    end
  end
  assign stb_o   = stb_q;
  assign press_o = press_q;
endmodule

// File: rtl/key_counter.sv
// key_counter: three debounced buttons driving a 3-bit up/down counter with clear.
module key_counter
  import key_counter_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int DB_W      = 17
) (
  input  logic       CLK12M,
  input  logic       RST,
  input  logic       BTN0,
  input  logic       BTN1,
  input  logic       BTN2,
  output logic [2:0] CNT,
  output logic       CNT_STB,
  output logic [2:0] KEY_DOWN
);
  logic [2:0] btn_n, press, cnt_q, cnt_d;
  logic cnt_stb_q, cnt_stb_d, inc, dec;
  assign btn_n = {BTN2, BTN1, BTN0};
  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
      .clk    (CLK12M),
      .rst    (RST),
      .btn_n_i(btn_n[k]),
      .stb_o  (KEY_DOWN[k]),
      .press_o(press[k])
    );
  end
  // simultaneous inc and dec cancel out; clear overrides both
  always_comb begin
    inc       = press[KEY_INC] & ~press[KEY_DEC];
    dec       = press[KEY_DEC] & ~press[KEY_INC];
    cnt_d     = press[KEY_CLR] ? 3'd0 : inc ? cnt_q + 3'd1 : dec ? cnt_q - 3'd1 : cnt_q;
    cnt_stb_d = press[KEY_CLR] | inc | dec;
  end
  always_ff @(posedge CLK12M or posedge RST) begin
    if (RST) begin
      cnt_q     <= 3'd0;
      cnt_stb_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cnt_stb_q <= cnt_stb_d;
    end
  end
  assign CNT     = cnt_q;
  assign CNT_STB = cnt_stb_q;
endmodule
